// File: rtl/ship_placement.sv
// rtl/ship_placement.sv - 5x5 ship placement FSM with confirm-edge detection and occupancy checks
// Optional orthogonal-adjacency rejection enabled by defining SHIP_ADJACENCY_CHECK_EN.
module ship_placement (
    input  logic        clk,
    input  logic        rst,
    input  logic        ships_decided,
    input  logic [2:0]  player_amount_ships,
    input  logic [2:0]  cursor_row,
    input  logic [2:0]  cursor_col,
    input  logic        place_confirm,
    output logic [24:0] board,
    output logic [2:0]  ships_placed,
    output logic        place_error,
    output logic        placement_done
);

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  target_q, target_d;
    logic [24:0] board_q, board_d;
    logic [2:0]  placed_q, placed_d;
    logic        error_q, error_d;
    logic        confirm_prev_q, confirm_prev_d;

    logic        confirm_edge;
    logic        in_range;
    logic        blocked;
    logic [4:0]  cell_idx;
    logic [24:0] cell_mask;
`ifdef SHIP_ADJACENCY_CHECK_EN
    logic [24:0] neighbor_mask;
`endif

    always_comb begin
        confirm_edge = place_confirm & ~confirm_prev_q;
        in_range     = (cursor_row < 3'd5) && (cursor_col < 3'd5);
        cell_idx     = 5'(cursor_row) * 5'd5 + 5'(cursor_col);
        cell_mask    = in_range ? (25'd1 << cell_idx) : 25'd0;
        blocked      = |(board_q & cell_mask);
`ifdef SHIP_ADJACENCY_CHECK_EN
        // Row/column guards stop left/right shifts from wrapping onto the neighbouring row.
        neighbor_mask = '0;
        if (cursor_row != 3'd0) neighbor_mask = neighbor_mask | (cell_mask >> 5);
        if (cursor_row < 3'd4)  neighbor_mask = neighbor_mask | (cell_mask << 5);
        if (cursor_col != 3'd0) neighbor_mask = neighbor_mask | (cell_mask >> 1);
        if (cursor_col < 3'd4)  neighbor_mask = neighbor_mask | (cell_mask << 1);
        blocked = blocked | (|(board_q & neighbor_mask));
`endif
    end

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        board_d        = board_q;
        placed_d       = placed_q;
        error_d        = 1'b0;
        confirm_prev_d = place_confirm;
        case (state_q)
            IDLE: begin
                if (ships_decided && player_amount_ships != 3'd0 && player_amount_ships <= 3'd5) begin
                    target_d = player_amount_ships;
                    state_d  = PLACE;
                end
            end
            PLACE: begin
                if (confirm_edge) begin
                    if (in_range && !blocked) begin
                        board_d  = board_q | cell_mask;
                        placed_d = placed_q + 3'd1;
                        if (placed_q + 3'd1 == target_q) state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            target_q       <= 3'd0;
            board_q        <= 25'd0;
            placed_q       <= 3'd0;
            error_q        <= 1'b0;
            confirm_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            board_q        <= board_d;
            placed_q       <= placed_d;
            error_q        <= error_d;
            confirm_prev_q <= confirm_prev_d;
        end
    end

    assign board          = board_q;
    assign ships_placed   = placed_q;
    assign place_error    = error_q;
    assign placement_done = (state_q == DONE);

endmodule

// File: tb/tb_ship_placement.sv
// tb/tb_ship_placement.sv - directed self-checking bench for ship_placement
module tb_ship_placement;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ships_decided = 1'b0;
    logic [2:0]  player_amount_ships = 3'd0;
    logic [2:0]  cursor_row = 3'd0;
    logic [2:0]  cursor_col = 3'd0;
    logic        place_confirm = 1'b0;
    logic [24:0] board;
    logic [2:0]  ships_placed;
    logic        place_error;
    logic        placement_done;

    int tests_run = 0;
    int tests_failed = 0;

    ship_placement dut (
        .clk                 (clk),
        .rst                 (rst),
        .ships_decided       (ships_decided),
        .player_amount_ships (player_amount_ships),
        .cursor_row          (cursor_row),
        .cursor_col          (cursor_col),
        .place_confirm       (place_confirm),
        .board               (board),
        .ships_placed        (ships_placed),
        .place_error         (place_error),
        .placement_done      (placement_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [24:0] b, input logic [2:0] n,
                             input logic err, input logic done);
        chk({tag, "_board"}, 32'(board), 32'(b));
        chk({tag, "_placed"}, 32'(ships_placed), 32'(n));
        chk({tag, "_error"}, 32'(place_error), 32'(err));
        chk({tag, "_done"}, 32'(placement_done), 32'(done));
    endtask

    // Raise confirm for one cycle; outputs are sampled just after the acting edge.
    task automatic press(input logic [2:0] r, input logic [2:0] c);
        cursor_row    = r;
        cursor_col    = c;
        place_confirm = 1'b1;
        tick();
    endtask

    task automatic release_btn();
        place_confirm = 1'b0;
        tick();
    endtask

    task automatic accept(input logic [2:0] amt);
        ships_decided       = 1'b1;
        player_amount_ships = amt;
        tick();
        ships_decided       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        chk_state("reset", 25'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Amount 0 ignored; confirm edges in IDLE ignored
        ships_decided       = 1'b1;
        player_amount_ships = 3'd0;
        tick();
        tick();
        chk_state("amt0", 25'd0, 3'd0, 1'b0, 1'b0);
        player_amount_ships = 3'd6;
        press(3'd0, 3'd0);
        chk_state("amt6_idle_edge", 25'd0, 3'd0, 1'b0, 1'b0);
        release_btn();
        ships_decided = 1'b0;
        press(3'd1, 3'd1);
        chk_state("idle_edge", 25'd0, 3'd0, 1'b0, 1'b0);
        release_btn();

        // Three ships on the diagonal
        accept(3'd3);
        press(3'd0, 3'd0);
        chk_state("three_a", 25'h0000001, 3'd1, 1'b0, 1'b0);
        release_btn();
        press(3'd2, 3'd2);
        chk_state("three_b", 25'h0001001, 3'd2, 1'b0, 1'b0);
        release_btn();
        press(3'd4, 3'd4);
        chk_state("three_c", 25'h1001001, 3'd3, 1'b0, 1'b1);
        release_btn();
        ships_decided       = 1'b1;
        player_amount_ships = 3'd5;
        press(3'd1, 3'd1);
        chk_state("done_hold", 25'h1001001, 3'd3, 1'b0, 1'b1);
        release_btn();
        ships_decided = 1'b0;

        // Async reset clears without a clock edge
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_state("async_rst", 25'd0, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Duplicate cell and out-of-range row each pulse error once
        accept(3'd2);
        press(3'd1, 3'd1);
        chk_state("dup_first", 25'h0000040, 3'd1, 1'b0, 1'b0);
        release_btn();
        chk("dup_err_idle", 32'(place_error), 32'd0);
        press(3'd1, 3'd1);
        chk_state("dup_second", 25'h0000040, 3'd1, 1'b1, 1'b0);
        release_btn();
        chk("dup_err_pulse_end", 32'(place_error), 32'd0);
        press(3'd5, 3'd0);
        chk_state("row5", 25'h0000040, 3'd1, 1'b1, 1'b0);
        release_btn();
        chk("row5_pulse_end", 32'(place_error), 32'd0);
        press(3'd0, 3'd7);
        chk_state("col7", 25'h0000040, 3'd1, 1'b1, 1'b0);
        release_btn();

        // Reset mid-PLACE discards placements; later edges need a new acceptance
        do_reset();
        accept(3'd4);
        press(3'd3, 3'd3);
        release_btn();
        press(3'd0, 3'd4);
        release_btn();
        chk_state("mid_place", 25'h0040010, 3'd2, 1'b0, 1'b0);
        do_reset();
        chk_state("mid_reset", 25'd0, 3'd0, 1'b0, 1'b0);
        press(3'd2, 3'd2);
        chk_state("post_reset_edge", 25'd0, 3'd0, 1'b0, 1'b0);
        release_btn();

        // Confirm already high on entry; held confirm; target frozen against later ships_decided
        do_reset();
        cursor_row          = 3'd0;
        cursor_col          = 3'd0;
        place_confirm       = 1'b1;
        ships_decided       = 1'b1;
        player_amount_ships = 3'd2;
        tick();
        player_amount_ships = 3'd5;
        tick();
        tick();
        chk_state("held_entry", 25'd0, 3'd0, 1'b0, 1'b0);
        release_btn();
        press(3'd0, 3'd0);
        for (int i = 0; i < 9; i++) tick();
        chk_state("held_ten", 25'h0000001, 3'd1, 1'b0, 1'b0);
        release_btn();
        ships_decided = 1'b0;
`ifdef SHIP_ADJACENCY_CHECK_EN
        press(3'd0, 3'd1);
        chk_state("adj_reject", 25'h0000001, 3'd1, 1'b1, 1'b0);
        release_btn();
        press(3'd1, 3'd1);
        chk_state("adj_accept", 25'h0000041, 3'd2, 1'b0, 1'b1);
        release_btn();
`else
        press(3'd0, 3'd1);
        chk_state("adj_allowed", 25'h0000003, 3'd2, 1'b0, 1'b1);
        release_btn();
`endif
        chk("final_done", 32'(placement_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
